// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives a 1-cycle synchronous imem, feeds IF/DE with a 1-entry skid.
// Optional stall/flush performance counters are built when FETCH_PERF_CNT_EN is defined.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_INC   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        de_ready,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] inst_out,
    output logic [31:0] pc_out,
    output logic        inst_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);

    localparam logic [31:0] PC_STEP = 32'(PC_INC);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STALL
    } state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic        req_n;
    logic        infl_v, infl_v_n;
    logic [31:0] infl_pc, infl_pc_n;
    logic        skid_v, skid_v_n;
    logic [31:0] skid_inst, skid_inst_n;
    logic [31:0] skid_pc, skid_pc_n;
    logic [31:0] inst_n, pc_out_n;
    logic        valid_n;
    logic        stall;
    logic [31:0] redirect_pc;

    // pc always names the address on the imem bus, so it doubles as imem_addr
    assign imem_addr   = pc;
    assign stall       = inst_valid && !de_ready;
    assign redirect_pc = branch_target & 32'hFFFF_FFFC;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            imem_req   <= 1'b0;
            infl_v     <= 1'b0;
            infl_pc    <= '0;
            skid_v     <= 1'b0;
            skid_inst  <= '0;
            skid_pc    <= '0;
            inst_out   <= '0;
            pc_out     <= '0;
            inst_valid <= 1'b0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            imem_req   <= req_n;
            infl_v     <= infl_v_n;
            infl_pc    <= infl_pc_n;
            skid_v     <= skid_v_n;
            skid_inst  <= skid_inst_n;
            skid_pc    <= skid_pc_n;
            inst_out   <= inst_n;
            pc_out     <= pc_out_n;
            inst_valid <= valid_n;
        end
    end

    // On a stall the request issued in that cycle is dropped (no room for it)
    // and reissued from the held pc once decode accepts again.
    always_comb begin
        state_n     = state;
        pc_n        = pc;
        req_n       = imem_req;
        infl_v_n    = 1'b0;
        infl_pc_n   = pc;
        skid_v_n    = skid_v;
        skid_inst_n = skid_inst;
        skid_pc_n   = skid_pc;
        inst_n      = inst_out;
        pc_out_n    = pc_out;
        valid_n     = inst_valid;

        if (branch_taken) begin
            state_n  = RUN;
            pc_n     = redirect_pc;
            req_n    = 1'b1;
            valid_n  = 1'b0;
            skid_v_n = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    state_n = RUN;
                    req_n   = 1'b1;
                end
                RUN: begin
                    if (stall) begin
                        state_n = STALL;
                        req_n   = 1'b0;
                        if (infl_v) begin
                            skid_v_n    = 1'b1;
                            skid_inst_n = imem_rdata;
                            skid_pc_n   = infl_pc;
                        end
                    end else begin
                        req_n    = 1'b1;
                        infl_v_n = imem_req;
                        if (imem_req) begin
                            pc_n = pc + PC_STEP;
                        end
                        valid_n = infl_v;
                        if (infl_v) begin
                            inst_n   = imem_rdata;
                            pc_out_n = infl_pc;
                        end
                    end
                end
                STALL: begin
                    if (!stall) begin
                        state_n  = RUN;
                        req_n    = 1'b1;
                        valid_n  = skid_v;
                        skid_v_n = 1'b0;
                        if (skid_v) begin
                            inst_n   = skid_inst;
                            pc_out_n = skid_pc;
                        end
                    end
                end
                default: begin
                    state_n = IDLE;
                    req_n   = 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (branch_taken && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage that produces the instruction word for the IF/DE pipeline register.
- Owns the PC and drives a synchronous instruction memory with 1-cycle read latency.
- Presents {inst_out, pc_out, inst_valid} to the decode side, with back-pressure (de_ready) and branch redirect/flush.
- Delivers up to 1 instruction/cycle; a 1-entry skid buffer absorbs the in-flight read during a stall.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned.
- PC_INC, 4, byte increment per sequential fetch.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- imem_req  out  1  read request this cycle (registered)
- imem_addr  out  32  read address, valid while imem_req=1 (registered)
- imem_rdata  in  32  data for the previous cycle's accepted request
- de_ready  in  1  decode accepts inst_out this cycle
- branch_taken  in  1  redirect request, single-cycle pulse
- branch_target  in  32  redirect address; bits [1:0] ignored (forced 0)
- inst_out  out  32  instruction to IF/DE register
- pc_out  out  32  address of inst_out
- inst_valid  out  1  inst_out/pc_out valid

Behaviour:
- Reset (async assert, sync release): pc=RESET_PC; imem_req=0; imem_addr=RESET_PC; inst_out=0; pc_out=0; inst_valid=0; skid empty; state=IDLE.
- Memory timing: request at cycle c returns imem_rdata in cycle c+1; the unit registers it, so inst_out is visible at c+2. An in-flight tag (1 bit + address) tracks each outstanding request.
- Transfer: the decode side takes inst_out when inst_valid && de_ready.
- State IDLE: the first cycle after reset release. Assert imem_req with imem_addr=pc, then go to RUN.
- State RUN:
  - Each cycle with imem_req=1, the next cycle's imem_addr = previous + PC_INC (mod 2^32, wraps 32'hFFFF_FFFC -> 0).
  - Returned data loads inst_out/pc_out and sets inst_valid=1 when the output is empty or is being transferred this cycle.
  - inst_valid drops to 0 when a transfer occurs and no new data arrives.
- Stall: if inst_valid && !de_ready:
  - inst_out, pc_out and inst_valid hold.
  - imem_req drops next cycle and the pc holds.
  - A response arriving in that cycle goes to the skid register; state becomes STALL.
- State STALL (skid full): imem_req=0. On de_ready=1, the skid moves to inst_out next cycle, imem_req reasserts with the next sequential pc, and state returns to RUN. There are no bubbles beyond the memory latency.
- Redirect (branch_taken=1 in cycle k), in any state, with priority over stall and over arriving data:
  - At cycle k+1: pc=imem_addr={branch_target[31:2],2'b00}; imem_req=1.
  - inst_valid=0 at k+1 and k+2; the skid is cleared.
  - Any response for a pre-redirect request is discarded.
  - inst_out = mem[target] with inst_valid=1 at k+3.
  - State=RUN.
- branch_taken together with a pending transfer: the current inst_out is still transferred in cycle k if de_ready=1. It is never re-presented.
- Back-to-back branch_taken: the latest target wins; each redirect restarts the k+1..k+3 timing.
- Reset asserted mid-operation: all state clears immediately; in-flight data is dropped.
- Invariants: inst_out never changes while inst_valid && !de_ready. No instruction is duplicated or skipped except by redirect.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: adds outputs stall_cnt[31:0] and flush_cnt[31:0], both reset to 0 and saturating at 32'hFFFF_FFFF.
  - stall_cnt increments each cycle with inst_valid && !de_ready.
  - flush_cnt increments each cycle with branch_taken=1.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset then de_ready=1 continuously, memory word = address -> imem_addr 0,4,8,... from cycle 1; inst_out=0,4,8... with inst_valid=1 from cycle 3, one per cycle.
- de_ready=0 for 3 cycles while inst_out=0x8 -> inst_out/pc_out hold 0x8, imem_req=0, skid holds 0xC. After release: 0xC next, then 0x10, with no loss or duplicate.
- branch_taken with target 0x103 at cycle k -> imem_addr=0x100 at k+1; inst_valid=0 at k+1 and k+2; inst_out=mem[0x100], pc_out=0x100 at k+3; stale data discarded.
- branch_taken while stalled with skid full -> skid cleared; after k+3 only target-stream instructions appear.
- RESET_PC=32'hFFFF_FFF8 -> fetch order FFFF_FFF8, FFFF_FFFC, 0000_0000.
- rst_n pulsed low mid-stream -> all outputs zero asynchronously; fetch restarts at RESET_PC. With FETCH_PERF_CNT_EN, after 3 stall cycles and 2 branches: stall_cnt=3, flush_cnt=2.
